cfglut5_loader: RTL

- Sequential writer for a bank of Xilinx CFGLUT5 reconfigurable LUTs. LUT6-class primitives only read INIT; this block writes it.
- Accepts a 32-bit INIT word plus a target LUT index over a valid/ready handshake.
- Shifts the word into the selected CFGLUT5 through its CDI/CE pins, and captures the old contents from CDO as readback.
- Sits between a soft CPU/config register file and a group of CFGLUT5 instances sharing one CDI net.

---
 rtl/cfglut_pkg.sv | 6 +
 rtl/cfglut5_loader_cfglut5.sv | 29 ++
 rtl/cfglut5_loader.sv | 68 ++++++
 3 files changed

// File: rtl/cfglut_pkg.sv
// cfglut_pkg: shared widths and FSM encoding for the CFGLUT5 loader
package cfglut_pkg;
  localparam int INIT_W = 32;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/cfglut5_loader_cfglut5.sv
// CFGLUT5: behavioural model of the Xilinx reconfigurable 5-input LUT
module CFGLUT5 #(
  parameter logic [31:0] INIT = 32'h0
) (
  input  logic CDI,
  input  logic CE,
  input  logic CLK,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic I4,
  output logic O5,
  output logic O6,
  output logic CDO
);
  logic [5:0] r_n;
  logic [31:0] r_in, w_q;
  // Registers power up at zero, so contents are INIT pushed up by the r_n bits loaded into r_in
  always_ff @(posedge CLK)
    if (CE) begin
      r_n <= r_n + 6'(!r_n[5]);
      r_in <= {r_in[30:0], CDI};
    end
  assign w_q = r_n[5] ? r_in : (INIT << r_n) | r_in;
  assign O6 = w_q[{I4, I3, I2, I1, I0}];
  assign O5 = w_q[{1'b0, I3, I2, I1, I0}];
  assign CDO = w_q[31];
endmodule

// File: rtl/cfglut5_loader.sv
// cfglut5_loader: serial INIT writer and readback engine for a bank of CFGLUT5
module cfglut5_loader
  import cfglut_pkg::*;
#(
  parameter int NUM_LUTS = 4,
  parameter int SEL_W = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_VLD,
  output logic                WR_RDY,
  input  logic [SEL_W-1:0]    WR_SEL,
  input  logic [INIT_W-1:0]   WR_INIT,
  input  logic                WR_KEEP,
  output logic                CDI,
  output logic [NUM_LUTS-1:0] CE,
  input  logic [NUM_LUTS-1:0] CDO,
  output logic                RB_VLD,
  output logic [INIT_W-1:0]   RB_DATA,
  output logic                RB_ERR,
  output logic                BUSY
);
  localparam int SEL_N = 2 ** SEL_W;
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [INIT_W-1:0] r_sh, r_rb;
  logic [SEL_W-1:0] r_sel;
  logic r_keep, r_err;
  logic w_acc, w_shift, w_cdo;
  logic [SEL_N-1:0] w_cdo_all, w_hot;
  // Widen to the full index range so an out-of-range select reads a defined zero
  assign w_cdo_all = SEL_N'(CDO);
  assign w_hot = SEL_N'(1) << r_sel;
  assign w_shift = r_state == ST_SHIFT;
  assign w_acc = WR_VLD && WR_RDY;
  assign w_cdo = !r_err && w_cdo_all[r_sel];
  assign WR_RDY = r_state == ST_IDLE;
  assign BUSY = !WR_RDY;
  assign CE = (w_shift && !r_err) ? w_hot[NUM_LUTS-1:0] : '0;
  assign CDI = w_shift && (r_keep ? w_cdo : !r_err && r_sh[INIT_W-1]);
  assign RB_VLD = r_state == ST_DONE;
  assign RB_ERR = RB_VLD && r_err;
  assign RB_DATA = r_rb;
  always_ff @(posedge CLK)
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_sh <= '0;
      r_rb <= '0;
      r_sel <= '0;
      r_keep <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_acc ? ST_SHIFT :
                 w_shift ? (r_cnt == CNT_W'(INIT_W - 1) ? ST_DONE : ST_SHIFT) : ST_IDLE;
      if (w_acc) begin
        r_sh <= WR_INIT;
        r_sel <= WR_SEL;
        r_keep <= WR_KEEP;
        r_err <= 32'(WR_SEL) >= NUM_LUTS;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sh <= r_sh << 1;
        r_rb <= {r_rb[INIT_W-2:0], w_cdo};
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
endmodule
